// File: rtl/arb_channel_memory_pkg.sv
`default_nettype none
// ============================================================================
// Module      : arb_channel_memory_pkg
// Description : Shared definitions for the arbitrated channel memory.
//               - Default geometry constants.
//               - Request and response record types at the default geometry.
//               - parity_f: the even-parity helper used by the parity build.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_channel_memory_pkg;

  localparam int c_WIDTH_DEF  = 8;
  localparam int c_DEPTH_DEF  = 256;
  localparam int c_ADDR_W_DEF = 8;
  localparam int c_NCH_DEF    = 4;
  localparam int c_CNT_W_DEF  = 16;

  typedef struct packed {
    logic                    we;
    logic [c_ADDR_W_DEF-1:0] addr;
    logic [c_WIDTH_DEF-1:0]  wdata;
  } mem_req_t;

  typedef struct packed {
    logic [c_WIDTH_DEF-1:0] rdata;
    logic                   err;
  } mem_rsp_t;

  // Even parity over a word of up to 64 bits.
  // Zero-extending a narrower word does not change the result.
  function automatic logic parity_f(input logic [63:0] d);
    return ^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_channel_memory_if.sv
`default_nettype none
// ============================================================================
// Module      : arb_channel_memory_if
// Description : Request/response bus between the requester channels and the
//               channel memory. Channel c occupies bit c of every per-channel
//               vector.
//   The address and data fields of channel c sit at [c*W +: W].
//   Modports:
//   - master : the requester side. It drives the requests and rsp_ready.
//   - slave  : the memory side. It drives req_ready and the response fields.
// Revision    : 1.0 - initial release
// ============================================================================
interface arb_channel_memory_if #(
  parameter int NCH    = 4,
  parameter int ADDR_W = 8,
  parameter int WIDTH  = 8
);
  logic [NCH-1:0]        req_valid;
  logic [NCH-1:0]        req_ready;
  logic [NCH-1:0]        req_we;
  logic [NCH*ADDR_W-1:0] req_addr;
  logic [NCH*WIDTH-1:0]  req_wdata;
  logic [NCH-1:0]        rsp_valid;
  logic [NCH-1:0]        rsp_ready;
  logic [NCH*WIDTH-1:0]  rsp_rdata;
  logic [NCH-1:0]        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface
`default_nettype wire

// File: rtl/arb_channel_memory_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : arb_channel_memory_rr_arbiter
// Description : Combinational round-robin arbiter.
//   The search starts at ptr and wraps around.
//   Ports:
//   - req     : request vector, one bit per requester.
//   - ptr     : index with the highest priority this cycle.
//   - gnt     : one-hot grant, or zero when nothing is requested.
//   - gnt_idx : index of the granted requester. It is 0 when there is no grant.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_channel_memory_rr_arbiter #(
  parameter  int N     = 4,
  localparam int PTR_W = (N > 1) ? $clog2(N) : 1
) (
  input  wire logic [N-1:0]     req,
  input  wire logic [PTR_W-1:0] ptr,
  output logic      [N-1:0]     gnt,
  output logic      [PTR_W-1:0] gnt_idx
);

  logic [N-1:0] w_mask;
  logic [N-1:0] w_cand;
  logic         w_found;

  // The search runs in two parts.
  // First, look at requesters at or above ptr.
  // If none of them is requesting, fall back to the lowest requester overall.
  // This gives the same result as a search that starts at ptr and wraps.
  always_comb begin
    w_mask  = '0;
    w_cand  = '0;
    gnt     = '0;
    gnt_idx = '0;
    w_found = 1'b0;
    for (int j = 0; j < N; j++) begin
      w_mask[j] = (j >= int'(ptr));
    end
    w_cand = (|(req & w_mask)) ? (req & w_mask) : req;
    for (int j = 0; j < N; j++) begin
      if (!w_found && w_cand[j]) begin
        gnt[j]  = 1'b1;
        gnt_idx = PTR_W'(j);
        w_found = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/arb_channel_memory.sv
`default_nettype none
// ============================================================================
// Module      : arb_channel_memory
// Description : A DEPTH x WIDTH memory shared by NCH requester channels.
//   A round-robin arbiter grants one access per clock.
//   Read data lands in a per-channel response slot one cycle after the grant.
//   The slot holds until the channel consumes it.
//   Ports:
//   - clk, rst_n : clock and asynchronous active-low reset.
//   - bus        : request/response interface (slave modport).
//   - rd_count   : reads accepted since reset. Saturates.
//   - wr_count   : writes accepted since reset. Saturates.
//   Build option MEM_PARITY_EN:
//   - Each word carries an even-parity bit.
//   - A read whose stored parity does not match flags rsp_err.
//   - The stored data is still returned.
// Revision    : 1.0 - initial release
// ============================================================================
module arb_channel_memory
  import arb_channel_memory_pkg::*;
#(
  parameter int WIDTH  = c_WIDTH_DEF,
  parameter int DEPTH  = c_DEPTH_DEF,
  parameter int ADDR_W = c_ADDR_W_DEF,
  parameter int NCH    = c_NCH_DEF,
  parameter int CNT_W  = c_CNT_W_DEF
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  arb_channel_memory_if.slave   bus,
  output logic      [CNT_W-1:0] rd_count,
  output logic      [CNT_W-1:0] wr_count
);

  localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;
`ifdef MEM_PARITY_EN
  localparam int MEM_W = WIDTH + 1;
`else
  localparam int MEM_W = WIDTH;
`endif

  // The array itself has no reset.
  logic [MEM_W-1:0]     r_mem [DEPTH];

  logic [PTR_W-1:0]     r_ptr;
  logic [NCH-1:0]       r_rsp_valid;
  logic [NCH-1:0]       r_rsp_err;
  logic [NCH*WIDTH-1:0] r_rsp_rdata;
  logic [CNT_W-1:0]     r_rd_count;
  logic [CNT_W-1:0]     r_wr_count;

  logic [NCH-1:0]       w_elig;
  logic [NCH-1:0]       w_gnt;
  logic [PTR_W-1:0]     w_gnt_idx;
  logic                 w_any_gnt;
  logic                 w_sel_we;
  logic [ADDR_W-1:0]    w_sel_addr;
  logic [WIDTH-1:0]     w_sel_wdata;
  logic                 w_in_range;
  logic [MEM_W-1:0]     w_rd_word;
  logic [MEM_W-1:0]     w_wr_word;
  logic [WIDTH-1:0]     w_rd_data;
  logic                 w_rd_err;

  // A read may only be granted when its slot is free, or when the slot is
  // being drained this same cycle.
  // The second case lets one channel sustain one read per clock.
  // Writes produce no response, so they are always eligible.
  assign w_elig = bus.req_valid & (bus.req_we | ~r_rsp_valid | bus.rsp_ready);

  arb_channel_memory_rr_arbiter #(.N(NCH)) u_arb (
    .req     (w_elig),
    .ptr     (r_ptr),
    .gnt     (w_gnt),
    .gnt_idx (w_gnt_idx)
  );

  assign w_any_gnt     = |w_gnt;
  assign bus.req_ready = w_gnt;

  // The grant is one-hot, so OR-ing the selected fields is an exact mux.
  always_comb begin
    w_sel_we    = 1'b0;
    w_sel_addr  = '0;
    w_sel_wdata = '0;
    for (int c = 0; c < NCH; c++) begin
      if (w_gnt[c]) begin
        w_sel_we    = bus.req_we[c];
        w_sel_addr  = bus.req_addr[c*ADDR_W +: ADDR_W];
        w_sel_wdata = bus.req_wdata[c*WIDTH +: WIDTH];
      end
    end
  end

  assign w_in_range = (int'(w_sel_addr) < DEPTH);
  assign w_rd_word  = w_in_range ? r_mem[w_sel_addr] : '0;
  assign w_rd_data  = w_rd_word[WIDTH-1:0];

`ifdef MEM_PARITY_EN
  // Stored word = {parity, data}. A correct word XORs to zero overall.
  assign w_wr_word = {parity_f(64'(w_sel_wdata)), w_sel_wdata};
  assign w_rd_err  = ~w_in_range | (^w_rd_word);
`else
  assign w_wr_word = w_sel_wdata;
  assign w_rd_err  = ~w_in_range;
`endif

  // A write to an out-of-range address is dropped.
  always_ff @(posedge clk) begin
    if (w_any_gnt && w_sel_we && w_in_range) begin
      r_mem[w_sel_addr] <= w_wr_word;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr       <= '0;
      r_rsp_valid <= '0;
      r_rsp_err   <= '0;
      r_rsp_rdata <= '0;
      r_rd_count  <= '0;
      r_wr_count  <= '0;
    end else begin
      // Each slot is either refilled by a read grant or drained by rsp_ready.
      // A refill takes priority, which covers a pop and refill in one cycle.
      for (int c = 0; c < NCH; c++) begin
        if (w_gnt[c] && !bus.req_we[c]) begin
          r_rsp_valid[c]                  <= 1'b1;
          r_rsp_err[c]                    <= w_rd_err;
          r_rsp_rdata[c*WIDTH +: WIDTH]   <= w_rd_data;
        end else if (bus.rsp_ready[c]) begin
          r_rsp_valid[c] <= 1'b0;
        end
      end

      if (w_any_gnt) begin
        r_ptr <= (int'(w_gnt_idx) == NCH - 1) ? '0 : w_gnt_idx + 1'b1;
        if (w_sel_we) begin
          if (r_wr_count != {CNT_W{1'b1}}) r_wr_count <= r_wr_count + 1'b1;
        end else begin
          if (r_rd_count != {CNT_W{1'b1}}) r_rd_count <= r_rd_count + 1'b1;
        end
      end
    end
  end

  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign rd_count      = r_rd_count;
  assign wr_count      = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_arb_channel_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_arb_channel_memory
// Description : Directed bench for arb_channel_memory. It uses two instances.
//   - dut_a : default geometry.
//   - dut_b : DEPTH = 200 and CNT_W = 4. Used for the range and saturation cases.
//   Build option MEM_PARITY_EN selects the expected parity-error result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arb_channel_memory;

  logic        clk;
  logic        rst_n;
  logic [15:0] rd_a, wr_a;
  logic [3:0]  rd_b, wr_b;
  int          n_vec;
  int          n_mis;
  int          tally [4];
  logic        exp_par_err;

  arb_channel_memory_if #(.NCH(4), .ADDR_W(8), .WIDTH(8)) bus_a ();
  arb_channel_memory_if #(.NCH(4), .ADDR_W(8), .WIDTH(8)) bus_b ();

  arb_channel_memory dut_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_a),
    .rd_count (rd_a),
    .wr_count (wr_a)
  );

  arb_channel_memory #(.DEPTH(200), .CNT_W(4)) dut_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_b),
    .rd_count (rd_b),
    .wr_count (wr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Leaves time at 1 ns after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req_a(input int ch, input bit v, input bit we, input int addr, input int data);
    bus_a.req_valid[ch]         = v;
    bus_a.req_we[ch]            = we;
    bus_a.req_addr[ch*8 +: 8]   = addr[7:0];
    bus_a.req_wdata[ch*8 +: 8]  = data[7:0];
  endtask

  task automatic req_b(input int ch, input bit v, input bit we, input int addr, input int data);
    bus_b.req_valid[ch]         = v;
    bus_b.req_we[ch]            = we;
    bus_b.req_addr[ch*8 +: 8]   = addr[7:0];
    bus_b.req_wdata[ch*8 +: 8]  = data[7:0];
  endtask

  initial begin
    n_vec = 0;
    n_mis = 0;
`ifdef MEM_PARITY_EN
    exp_par_err = 1'b1;
`else
    exp_par_err = 1'b0;
`endif
    rst_n           = 1'b0;
    bus_a.req_valid = '0; bus_a.req_we = '0; bus_a.req_addr = '0;
    bus_a.req_wdata = '0; bus_a.rsp_ready = '0;
    bus_b.req_valid = '0; bus_b.req_we = '0; bus_b.req_addr = '0;
    bus_b.req_wdata = '0; bus_b.rsp_ready = '0;

    // Reset state
    tick();
    tick();
    chk("rst_rsp_valid", 32'(bus_a.rsp_valid), 32'h0);
    chk("rst_rdata",     32'(bus_a.rsp_rdata), 32'h0);
    chk("rst_rd_count",  32'(rd_a), 32'h0);
    chk("rst_wr_count",  32'(wr_a), 32'h0);
    rst_n = 1'b1;
    tick();

    // 1. Write then read back on ch0, then reset with a response pending
    req_a(0, 1, 1, 3, 'hA5);
    #1 chk("t1_wr_ready", 32'(bus_a.req_ready), 32'h1);
    tick();
    req_a(0, 1, 0, 3, 0);
    #1 chk("t1_rd_ready", 32'(bus_a.req_ready), 32'h1);
    chk("t1_pre_valid", 32'(bus_a.rsp_valid), 32'h0);
    tick();
    chk("t1_valid", 32'(bus_a.rsp_valid), 32'h1);
    chk("t1_rdata", 32'(bus_a.rsp_rdata[7:0]), 32'hA5);
    chk("t1_err",   32'(bus_a.rsp_err[0]), 32'h0);
    chk("t1_wr_count", 32'(wr_a), 32'h1);
    chk("t1_rd_count", 32'(rd_a), 32'h1);
    req_a(0, 0, 0, 0, 0);
    tick();
    chk("t1_held", 32'(bus_a.rsp_valid), 32'h1);
    #2 rst_n = 1'b0;
    #1 chk("t1_rst_drop", 32'(bus_a.rsp_valid), 32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("t1_rd_cnt_clr", 32'(rd_a), 32'h0);
    chk("t1_wr_cnt_clr", 32'(wr_a), 32'h0);

    // 2. Contention: four channels reading every cycle
    for (int c = 0; c < 4; c++) begin
      req_a(c, 1, 0, 3, 0);
      tally[c] = 0;
    end
    bus_a.rsp_ready = 4'hF;
    for (int k = 0; k < 8; k++) begin
      #1 chk("t2_grant", 32'(bus_a.req_ready), 32'(1 << (k % 4)));
      for (int c = 0; c < 4; c++) if (bus_a.req_ready[c]) tally[c]++;
      tick();
      if (k == 0) chk("t2_rdata0", 32'(bus_a.rsp_rdata[7:0]), 32'hA5);
    end
    for (int c = 0; c < 4; c++) chk("t2_share", 32'(tally[c]), 32'd2);
    bus_a.req_valid = '0;
    tick();
    bus_a.rsp_ready = '0;

    // 3. Backpressure on ch1
    req_a(1, 1, 1, 7, 'h77);
    #1 chk("t3_wr_ready", 32'(bus_a.req_ready), 32'h2);
    tick();
    req_a(1, 1, 0, 7, 0);
    #1 chk("t3_rd_ready", 32'(bus_a.req_ready), 32'h2);
    tick();
    chk("t3_rdata", 32'(bus_a.rsp_rdata[15:8]), 32'h77);
    req_a(1, 1, 0, 3, 0);
    #1 chk("t3_blocked", 32'(bus_a.req_ready), 32'h0);
    tick();
    chk("t3_held_valid", 32'(bus_a.rsp_valid[1]), 32'h1);
    chk("t3_held_rdata", 32'(bus_a.rsp_rdata[15:8]), 32'h77);
    bus_a.rsp_ready[1] = 1'b1;
    #1 chk("t3_pop_refill", 32'(bus_a.req_ready), 32'h2);
    tick();
    chk("t3_refill_valid", 32'(bus_a.rsp_valid[1]), 32'h1);
    chk("t3_refill_rdata", 32'(bus_a.rsp_rdata[15:8]), 32'hA5);
    req_a(1, 0, 0, 0, 0);
    tick();
    chk("t3_drained", 32'(bus_a.rsp_valid[1]), 32'h0);
    bus_a.rsp_ready = '0;

    // 6. Parity: corrupt a stored bit, then read it back
    req_a(0, 1, 1, 5, 'h3C);
    tick();
    req_a(0, 0, 0, 0, 0);
    dut_a.r_mem[5] = dut_a.r_mem[5] ^ 1;
    req_a(0, 1, 0, 5, 0);
    tick();
    req_a(0, 0, 0, 0, 0);
    chk("t6_rdata", 32'(bus_a.rsp_rdata[7:0]), 32'h3D);
    chk("t6_err",   32'(bus_a.rsp_err[0]), 32'(exp_par_err));
    bus_a.rsp_ready = 4'hF;
    tick();
    bus_a.rsp_ready = '0;

    // 4. Out of range on dut_b (DEPTH = 200)
    req_b(0, 1, 1, 250, 'h11);
    tick();
    req_b(0, 1, 0, 250, 0);
    tick();
    req_b(0, 0, 0, 0, 0);
    chk("t4_valid", 32'(bus_b.rsp_valid[0]), 32'h1);
    chk("t4_rdata", 32'(bus_b.rsp_rdata[7:0]), 32'h0);
    chk("t4_err",   32'(bus_b.rsp_err[0]), 32'h1);
    chk("t4_wr_count", 32'(wr_b), 32'h1);
    chk("t4_rd_count", 32'(rd_b), 32'h1);
    bus_b.rsp_ready = 4'hF;
    tick();
    bus_b.rsp_ready = '0;

    // 5. Counter saturation on dut_b (CNT_W = 4)
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("t5_wr_clr", 32'(wr_b), 32'h0);
    req_b(2, 1, 1, 10, 'h5A);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 14) chk("t5_wr_15", 32'(wr_b), 32'd15);
    end
    req_b(2, 0, 0, 0, 0);
    chk("t5_wr_sat", 32'(wr_b), 32'd15);
    chk("t5_rd_zero", 32'(rd_b), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
